// File: rtl/dcache_ahb.sv
// Direct-mapped, write-back, write-allocate data cache with an AHB-Lite INCR4 refill/writeback
// port. Tags, state and data are held in flops, so hit detection and load data are combinational.
module dcache_ahb #(
  parameter int unsigned TAG_WIDTH = 22
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_wrdata,
  output logic [31:0] dbus_rddata,
  input  logic [3:0]  dbus_byteenable,
  input  logic        dbus_read,
  input  logic        dbus_write,
  output logic        dbus_stall,
  input  logic        dbus_hitwriteback,
  input  logic        dbus_hitinvalidate,
  output logic [31:0] AHB_haddr,
  output logic [1:0]  AHB_htrans,
  output logic        AHB_hwrite,
  output logic [2:0]  AHB_hsize,
  output logic [2:0]  AHB_hburst,
  output logic [3:0]  AHB_hprot,
  output logic [31:0] AHB_hwdata,
  output logic        AHB_sel,
  input  logic [31:0] AHB_hrdata,
  input  logic        AHB_hready_out,
  input  logic        AHB_hresp,
  output logic        AHB_hready_in
);
  localparam int unsigned IndexWidth = 28 - TAG_WIDTH;
  localparam int unsigned Lines      = 1 << IndexWidth;

  typedef enum logic [1:0] {StIdle, StWb, StFill} state_e;

  state_e               r_state, w_state_d;
  logic [Lines-1:0]     r_valid, r_dirty;
  logic [TAG_WIDTH-1:0] r_tag  [Lines];
  logic [31:0]          r_data [Lines][4];
  logic [2:0]           r_acnt, r_dcnt;
  logic                 r_wb_op, r_op_done;

  logic [TAG_WIDTH-1:0]  w_tag;
  logic [IndexWidth-1:0] w_idx;
  logic [1:0]            w_word;
  logic [27:0]           w_line_base;
  logic w_hit, w_rw, w_op, w_op_pend, w_stall, w_inv_now, w_wb_op;
  logic w_addr_phase, w_data_phase, w_last, w_done, w_wr_hit, w_unused;

  assign w_tag     = dbus_addr[31:32-TAG_WIDTH];
  assign w_idx     = dbus_addr[31-TAG_WIDTH:4];
  assign w_word    = dbus_addr[3:2];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_rw      = dbus_read || dbus_write;
  assign w_op      = dbus_hitwriteback || dbus_hitinvalidate;
  // r_op_done stops a cache op from re-firing after the line is refilled for the access.
  assign w_op_pend = w_op && !r_op_done;
  assign w_unused  = ^{AHB_hresp, dbus_addr[1:0]};

  assign w_addr_phase = (r_state != StIdle) && !r_acnt[2];
  assign w_data_phase = (r_dcnt != r_acnt);
  assign w_last       = AHB_hready_out && w_data_phase && (r_dcnt == 3'd3);
  assign w_done       = (r_state == StIdle) && (w_rw || w_op) && !w_stall;
  assign w_wr_hit     = (r_state == StIdle) && dbus_write && w_hit && !w_stall;

  always_comb begin
    w_state_d = r_state;
    w_stall   = 1'b0;
    w_inv_now = 1'b0;
    w_wb_op   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_op_pend && w_hit && r_dirty[w_idx]) begin
          w_stall   = 1'b1;
          w_wb_op   = 1'b1;
          w_state_d = StWb;
        end else if (w_op_pend && w_hit && dbus_hitinvalidate) begin
          w_inv_now = 1'b1;
          w_stall   = w_rw;
        end else if (w_rw && !w_hit) begin
          w_stall   = 1'b1;
          w_state_d = (r_valid[w_idx] && r_dirty[w_idx]) ? StWb : StFill;
        end
      end
      StWb: begin
        w_stall = 1'b1;
        if (w_last) w_state_d = r_wb_op ? StIdle : StFill;
      end
      StFill: begin
        w_stall = 1'b1;
        if (w_last) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= StIdle;
      r_acnt    <= '0;
      r_dcnt    <= '0;
      r_wb_op   <= 1'b0;
      r_op_done <= 1'b0;
      r_valid   <= '0;
      r_dirty   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_state_d != r_state) begin
        r_acnt <= '0;
        r_dcnt <= '0;
      end else if (AHB_hready_out) begin
        if (w_addr_phase) r_acnt <= r_acnt + 3'd1;
        if (w_data_phase) r_dcnt <= r_dcnt + 3'd1;
      end
      if (r_state == StIdle) begin
        if (w_done) r_op_done <= 1'b0;
        else if (w_op) r_op_done <= 1'b1;
        if (w_state_d == StWb) r_wb_op <= w_wb_op;
        if (w_inv_now) r_valid[w_idx] <= 1'b0;
        if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
      end
      if (r_state == StWb && w_last) begin
        r_dirty[w_idx] <= 1'b0;
        if (r_wb_op && dbus_hitinvalidate) r_valid[w_idx] <= 1'b0;
      end
      if (r_state != StFill && w_state_d == StFill) r_valid[w_idx] <= 1'b0;
      if (r_state == StFill && w_last) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == StFill && AHB_hready_out && w_data_phase) begin
      r_data[w_idx][r_dcnt[1:0]] <= AHB_hrdata;
    end
    if (r_state == StFill && w_last) r_tag[w_idx] <= w_tag;
    if (w_wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (dbus_byteenable[b]) r_data[w_idx][w_word][8*b +: 8] <= dbus_wrdata[8*b +: 8];
      end
    end
  end

  // Writeback targets the victim's stored tag; refill targets the requested tag.
  assign w_line_base = (r_state == StWb) ? {r_tag[w_idx], w_idx} : {w_tag, w_idx};

  assign AHB_haddr     = w_addr_phase ? {w_line_base, r_acnt[1:0], 2'b00} : 32'h0;
  assign AHB_htrans    = !w_addr_phase ? 2'b00 : ((r_acnt == 3'd0) ? 2'b10 : 2'b11);
  assign AHB_hwrite    = (r_state == StWb);
  assign AHB_hsize     = 3'b010;
  assign AHB_hburst    = 3'b011;
  assign AHB_hprot     = 4'b0011;
  assign AHB_hwdata    = r_data[w_idx][r_dcnt[1:0]];
  assign AHB_sel       = (r_state != StIdle);
  assign AHB_hready_in = AHB_hready_out;

  assign dbus_rddata = r_data[w_idx][w_word];
  assign dbus_stall  = w_stall;

endmodule

// File: tb/tb_dcache_ahb.sv
// Directed bench for dcache_ahb: AHB-Lite SRAM slave with programmable wait states,
// burst trace capture and a byte-masked ground-truth memory for CPU-visible data.
module tb_dcache_ahb;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] dbus_addr, dbus_wrdata, dbus_rddata;
  logic [3:0]  dbus_byteenable;
  logic        dbus_read, dbus_write, dbus_stall, dbus_hitwriteback, dbus_hitinvalidate;
  logic [31:0] AHB_haddr, AHB_hwdata, AHB_hrdata;
  logic [1:0]  AHB_htrans;
  logic        AHB_hwrite, AHB_sel, AHB_hready_out, AHB_hresp, AHB_hready_in;
  logic [2:0]  AHB_hsize, AHB_hburst;
  logic [3:0]  AHB_hprot;

  dcache_ahb #(.TAG_WIDTH(22)) dut (
    .clk(clk), .nrst(nrst),
    .dbus_addr(dbus_addr), .dbus_wrdata(dbus_wrdata), .dbus_rddata(dbus_rddata),
    .dbus_byteenable(dbus_byteenable), .dbus_read(dbus_read), .dbus_write(dbus_write),
    .dbus_stall(dbus_stall), .dbus_hitwriteback(dbus_hitwriteback),
    .dbus_hitinvalidate(dbus_hitinvalidate),
    .AHB_haddr(AHB_haddr), .AHB_htrans(AHB_htrans), .AHB_hwrite(AHB_hwrite),
    .AHB_hsize(AHB_hsize), .AHB_hburst(AHB_hburst), .AHB_hprot(AHB_hprot),
    .AHB_hwdata(AHB_hwdata), .AHB_sel(AHB_sel), .AHB_hrdata(AHB_hrdata),
    .AHB_hready_out(AHB_hready_out), .AHB_hresp(AHB_hresp), .AHB_hready_in(AHB_hready_in)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem  [4096];
  logic [31:0] gold [4096];
  logic        preload = 1'b1;
  logic        s_dp_valid, s_dp_write;
  logic [11:0] s_dp_idx;
  int          s_wcnt;
  int          s_waits = 0;
  logic [31:0] tr_addr [$];
  logic [12:0] tr_ctrl [$];

  function automatic logic [31:0] init_word(input int i);
    return (i == 'h401) ? 32'h11223344 : (32'hA5000000 + 32'(i) * 32'h00001357);
  endfunction

  assign AHB_hready_out = !s_dp_valid || (s_wcnt == s_waits);
  assign AHB_hrdata     = mem[s_dp_idx];
  assign AHB_hresp      = 1'b0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s_dp_valid <= 1'b0;
      s_dp_write <= 1'b0;
      s_dp_idx   <= '0;
      s_wcnt     <= 0;
      if (preload) for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
    end else if (AHB_hready_out) begin
      if (s_dp_valid && s_dp_write) mem[s_dp_idx] <= AHB_hwdata;
      s_dp_valid <= AHB_sel && AHB_htrans[1];
      s_dp_write <= AHB_hwrite;
      s_dp_idx   <= AHB_haddr[13:2];
      s_wcnt     <= 0;
      if (AHB_sel && AHB_htrans[1]) begin
        tr_addr.push_back(AHB_haddr);
        tr_ctrl.push_back({AHB_hburst, AHB_hsize, AHB_hprot, AHB_hwrite, AHB_htrans});
      end
    end else begin
      s_wcnt <= s_wcnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_burst(input string tag, input int base, input logic [31:0] addr,
                             input logic wr);
    for (int i = 0; i < 4; i++) begin
      check_eq({tag, "_addr"}, tr_addr[base+i], addr + 32'(4 * i));
      check_eq({tag, "_ctrl"}, 32'(tr_ctrl[base+i]),
               32'({3'b011, 3'b010, 4'b0011, wr, (i == 0) ? 2'b10 : 2'b11}));
    end
  endtask

  // One CPU request held until the first cycle with stall low; gold tracks completed stores.
  task automatic cpu(input logic rd, input logic wr, input logic hwb, input logic hinv,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rdata, output int stalls);
    @(negedge clk);
    dbus_read = rd; dbus_write = wr; dbus_hitwriteback = hwb; dbus_hitinvalidate = hinv;
    dbus_addr = addr; dbus_wrdata = wdata; dbus_byteenable = be;
    #1;
    stalls = 0;
    while (dbus_stall && stalls < 400) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (dbus_stall) check_eq("request_timeout", 32'(dbus_stall), 32'd0);
    rdata = dbus_rddata;
    @(posedge clk);
    #1;
    dbus_read = 1'b0; dbus_write = 1'b0; dbus_hitwriteback = 1'b0; dbus_hitinvalidate = 1'b0;
    if (wr) for (int k = 0; k < 4; k++) if (be[k]) gold[addr[13:2]][8*k +: 8] = wdata[8*k +: 8];
  endtask

  task automatic step(input string tag, input logic rd, input logic wr, input logic hwb,
                      input logic hinv, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
    logic [31:0] exp, got;
    int st;
    exp = gold[addr[13:2]];
    cpu(rd, wr, hwb, hinv, addr, wdata, be, got, st);
    if (rd) check_eq(tag, got, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int st, b;
    dbus_read = 1'b0; dbus_write = 1'b0; dbus_hitwriteback = 1'b0; dbus_hitinvalidate = 1'b0;
    dbus_addr = '0; dbus_wrdata = '0; dbus_byteenable = '0;
    for (int i = 0; i < 4096; i++) gold[i] = init_word(i);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    #1;
    check_eq("rst_stall", 32'(dbus_stall), 32'd0);
    check_eq("rst_htrans", 32'(AHB_htrans), 32'd0);
    check_eq("rst_sel", 32'(AHB_sel), 32'd0);
    check_eq("rst_hwrite", 32'(AHB_hwrite), 32'd0);
    check_eq("hready_loop", 32'(AHB_hready_in), 32'(AHB_hready_out));

    // Write miss allocates with one INCR4 refill, then the read hits.
    b = tr_addr.size();
    cpu(1'b0, 1'b1, 1'b0, 1'b0, 32'h80001000, 32'h12345678, 4'hF, rd, st);
    check_eq("t1_wr_stalled", 32'(st != 0), 32'd1);
    check_eq("t1_beats", 32'(tr_addr.size() - b), 32'd4);
    check_burst("t1_fill", b, 32'h80001000, 1'b0);
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 32'h80001000, 32'h0, 4'hF, rd, st);
    check_eq("t1_rd_stall", 32'(st), 32'd0);
    check_eq("t1_rd_data", rd, 32'h12345678);
    check_eq("idle_stall", 32'(dbus_stall), 32'd0);

    // Byte-lane merge on a hit.
    cpu(1'b0, 1'b1, 1'b0, 1'b0, 32'h80001004, 32'hAABBCCDD, 4'b0101, rd, st);
    check_eq("t2_wr_stall", 32'(st), 32'd0);
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 32'h80001004, 32'h0, 4'hF, rd, st);
    check_eq("t2_merge", rd, 32'h11BB33DD);

    // Conflict miss: dirty victim written back before the refill.
    cpu(1'b0, 1'b1, 1'b0, 1'b0, 32'h80000010, 32'hCAFEF00D, 4'hF, rd, st);
    b = tr_addr.size();
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 32'h80000410, 32'h0, 4'hF, rd, st);
    check_eq("t3_beats", 32'(tr_addr.size() - b), 32'd8);
    check_burst("t3_wb", b, 32'h80000010, 1'b1);
    check_burst("t3_fill", b + 4, 32'h80000410, 1'b0);
    check_eq("t3_rd", rd, init_word('h104));
    check_eq("t3_sram0", mem[4], 32'hCAFEF00D);
    check_eq("t3_sram1", mem[5], init_word(5));
    check_eq("t3_sram3", mem[7], init_word(7));

    // hitinvalidate on a dirty line.
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 32'h80000010, 32'h0, 4'hF, rd, st);
    check_eq("t4_refill", rd, 32'hCAFEF00D);
    cpu(1'b0, 1'b1, 1'b0, 1'b0, 32'h80000010, 32'h01020304, 4'hF, rd, st);
    b = tr_addr.size();
    cpu(1'b0, 1'b0, 1'b0, 1'b1, 32'h80000010, 32'h0, 4'hF, rd, st);
    check_eq("t4_inv_beats", 32'(tr_addr.size() - b), 32'd4);
    check_burst("t4_inv_wb", b, 32'h80000010, 1'b1);
    check_eq("t4_sram", mem[4], 32'h01020304);
    b = tr_addr.size();
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 32'h80000010, 32'h0, 4'hF, rd, st);
    check_eq("t4_miss_stalled", 32'(st != 0), 32'd1);
    check_burst("t4_fill", b, 32'h80000010, 1'b0);
    check_eq("t4_rd", rd, 32'h01020304);

    // hitwriteback: clean hit and miss are no-ops; dirty hit writes back and stays valid.
    b = tr_addr.size();
    cpu(1'b0, 1'b0, 1'b1, 1'b0, 32'h80000010, 32'h0, 4'hF, rd, st);
    check_eq("t5_clean_stall", 32'(st), 32'd0);
    cpu(1'b0, 1'b0, 1'b1, 1'b0, 32'h80002000, 32'h0, 4'hF, rd, st);
    check_eq("t5_miss_stall", 32'(st), 32'd0);
    check_eq("t5_no_burst", 32'(tr_addr.size() - b), 32'd0);
    cpu(1'b0, 1'b1, 1'b0, 1'b0, 32'h80000018, 32'h00000077, 4'b0001, rd, st);
    b = tr_addr.size();
    cpu(1'b0, 1'b0, 1'b1, 1'b0, 32'h80000018, 32'h0, 4'hF, rd, st);
    check_burst("t5_wb", b, 32'h80000010, 1'b1);
    check_eq("t5_sram", mem[6], gold[6]);
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 32'h80000018, 32'h0, 4'hF, rd, st);
    check_eq("t5_kept_valid", 32'(st), 32'd0);
    check_eq("t5_rd", rd, gold[6]);

    // Three wait states per beat; every read checked against the ground-truth memory.
    s_waits = 3;
    step("t6_s1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h80000020, 32'hDEADBEEF, 4'hF);
    step("t6_s2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000420, 32'h0, 4'hF);
    step("t6_s3", 1'b0, 1'b1, 1'b0, 1'b0, 32'h80000820, 32'h55667788, 4'b1010);
    step("t6_s4", 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000020, 32'h0, 4'hF);
    step("t6_s5", 1'b0, 1'b1, 1'b0, 1'b0, 32'h80000020, 32'h0BADF00D, 4'b0110);
    step("t6_s6", 1'b1, 1'b0, 1'b0, 1'b1, 32'h80000020, 32'h0, 4'hF);
    step("t6_s7", 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000820, 32'h0, 4'hF);
    step("t6_s8", 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000082C, 32'hFEEDFACE, 4'hF);
    step("t6_s9", 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000082C, 32'h0, 4'hF);
    step("t6_s10", 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000428, 32'h0, 4'hF);
    step("t6_s11", 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000020, 32'h0, 4'hF);
    check_eq("t6_sram_wb", mem['h20B], 32'hFEEDFACE);

    // Reset in the middle of a burst.
    s_waits = 0;
    preload = 1'b0;
    @(negedge clk);
    dbus_addr = 32'h80003000; dbus_read = 1'b1;
    repeat (2) @(negedge clk);
    dbus_read = 1'b0;
    nrst = 1'b0;
    #1;
    check_eq("mid_rst_htrans", 32'(AHB_htrans), 32'd0);
    check_eq("mid_rst_sel", 32'(AHB_sel), 32'd0);
    check_eq("mid_rst_stall", 32'(dbus_stall), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    b = tr_addr.size();
    cpu(1'b1, 1'b0, 1'b0, 1'b0, 32'h80003000, 32'h0, 4'hF, rd, st);
    check_eq("post_rst_beats", 32'(tr_addr.size() - b), 32'd4);
    check_burst("post_rst_fill", b, 32'h80003000, 1'b0);
    check_eq("post_rst_rd", rd, init_word('hC00));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dcache_ahb.md
Name: dcache_ahb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU data bus (dbus) and a single-master AHB-Lite bus to external SRAM.
- Hits complete with zero wait states.
- Misses stall the CPU while the block writes back a dirty victim line and refills with 4-beat INCR4 bursts.
- Also performs CACHE hit-writeback and hit-invalidate operations.

Parameters:
- TAG_WIDTH, 22, address tag bits [31:32-TAG_WIDTH].
- Line size is fixed at 4 words (offset = addr[3:0]).
- INDEX_WIDTH = 28-TAG_WIDTH (default 6, i.e. 64 lines, 1 KiB).

Ports:
- clk in 1: clock, all state updates on rising edge.
- nrst in 1: asynchronous active-low reset.
- dbus_addr in 32: byte address; word = addr[31:2].
- dbus_wrdata in 32: store data.
- dbus_rddata out 32: load data.
- dbus_byteenable in 4: byte lanes, bit0 = [7:0].
- dbus_read in 1: load request.
- dbus_write in 1: store request.
- dbus_stall out 1: request not complete; CPU holds all dbus inputs.
- dbus_hitwriteback in 1: write back line at addr if hit and dirty.
- dbus_hitinvalidate in 1: write back if dirty, then invalidate, on hit.
- AHB_haddr out 32, AHB_htrans out 2, AHB_hwrite out 1, AHB_hsize out 3, AHB_hburst out 3, AHB_hprot out 4, AHB_hwdata out 32, AHB_sel out 1.
- AHB_hrdata in 32, AHB_hready_out in 1 (slave ready), AHB_hresp in 1.
- AHB_hready_in out 1: equals AHB_hready_out (single-slave loopback).

Behaviour:
- Storage: per line valid, dirty, tag, 4x32 data, held in registers so lookup is combinational.
- Hit = valid[idx] && tag[idx]==addr[31:32-TAG_WIDTH].
- Reset: all valid/dirty = 0, FSM IDLE, AHB_htrans = IDLE (2'b00), AHB_sel = 0, AHB_hwrite = 0, dbus_stall = 0.
- Read hit: dbus_stall = 0 in the same cycle; dbus_rddata = line word addr[3:2], full 32 bits regardless of byteenable.
- Write hit: dbus_stall = 0 in the same cycle. At the clock edge, merge the enabled bytes into the word and set dirty.
- Miss (read or write): dbus_stall goes high combinationally in the request cycle.
  - FSM IDLE -> WB (only if the victim is valid and dirty) -> FILL -> IDLE.
  - The access then completes as a hit; a write then merges and sets dirty.
- WB: 4-beat write burst to {victim_tag, idx, 4'h0}, incrementing by 4. Victim dirty bit cleared at burst end.
- FILL: 4-beat read burst from {addr tag, idx, 4'h0}. Each beat's hrdata written into the line. At end: valid = 1, dirty = 0, tag updated.
- AHB burst signalling:
  - Beat 0 has htrans NONSEQ (2'b10); beats 1-3 SEQ (2'b11).
  - hburst INCR4 (3'b011), hsize word (3'b010), hprot 4'b0011.
  - sel = 1 for the whole burst.
- AHB pipelining:
  - Address phase n+1 overlaps data phase n.
  - Address/control and hwdata advance only on a clock edge with AHB_hready_out = 1.
  - hwdata for beat n is presented in the cycle after its address phase is accepted.
  - After the last address: htrans = IDLE; wait for the final data phase hready_out.
- AHB_hresp is ignored (error treated as OKAY).
- hitwriteback: hit && dirty -> WB burst of that line, then clear dirty, valid kept. Otherwise no stall.
- hitinvalidate: on hit, WB if dirty, then valid = 0. Miss: no action, no stall.
- Stall is high while either cache op is busy.
- Cache op plus read/write in the same request: cache op first, then the access. Stall is low only once both are done.
- Stall is never asserted when no request/op is active.
- The request is considered complete at the rising edge where it is active and dbus_stall = 0.
- Reset mid-burst: FSM aborts to IDLE, the line stays invalid, AHB goes IDLE immediately.

Test Plan:
- After reset, write 0x12345678 BE=1111 to 0x80001000, then read 0x80001000: stall asserted for 1 fill (4 beats, INCR4 NONSEQ/SEQ×3 at 0x80001000..0x8000100C). Read returns 0x12345678 with no stall.
- Write 0xAABBCCDD BE=0101 to a word preloaded as 0x11223344 in SRAM: a later read returns 0x11BB33DD.
- Conflict: dirty line at 0x80000010, then read 0x80000410 (same index, TAG 22): write burst to 0x80000010..1C with old data, then read burst. SRAM holds the written values afterwards.
- hitinvalidate on dirty 0x80000010: 4-beat write-back, then a read of 0x80000010 misses and refills with the same value.
- hitwriteback on a clean line or a miss: dbus_stall stays 0 and htrans stays IDLE.
- Slave inserting 3 wait states per beat (hready_out low): the burst completes correctly and the data matches a byte-masked ground-truth memory on every completed read.
